// File: rtl/uart_tx_pkg.sv
// Shared types and line constants for the UART transmit framer.
package uart_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  // Payload is zero-extended to 9 bits so any width in 5..9 can use it.
  function automatic logic calc_parity(input logic [8:0] d, input logic typ);
    return (typ == PAR_EVEN) ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmit framer.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= data;
      cnt   <= '0;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  // shreg[0] is the bit on the line during DATA; ser_bit is the bit to drive next.
  assign ser_bit  = shift_en ? shreg[1] : shreg[0];
  assign ser_done = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  state_t state;
  logic   par_en_q, par_q;
  logic   last_stop, accept, shift_en;
  logic   ser_bit, ser_done;

`ifdef UART_TX_TWO_STOP_EN
  logic stop_cnt;
  assign last_stop = stop_cnt;
`else
  assign last_stop = 1'b1;
`endif

  assign accept   = Data_Valid && ((state == IDLE) || ((state == STOP) && last_stop));
  assign shift_en = (state == DATA) && !ser_done;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (accept),
    .shift_en (shift_en),
    .data     (P_DATA),
    .ser_bit  (ser_bit),
    .ser_done (ser_done)
  );

  // Outputs are loaded with the value for the state being entered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      TX_OUT   <= IDLE_LINE;
      Busy     <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt <= 1'b0;
`endif
    end else begin
      if (accept) begin
        par_en_q <= PAR_EN;
        par_q    <= calc_parity(9'(P_DATA), PAR_TYP);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= START;
            TX_OUT <= START_BIT;
            Busy   <= 1'b1;
          end else begin
            TX_OUT <= IDLE_LINE;
            Busy   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          TX_OUT <= ser_bit;
        end
        DATA: begin
          if (!ser_done) begin
            TX_OUT <= ser_bit;
          end else if (par_en_q) begin
            state  <= PARITY;
            TX_OUT <= par_q;
          end else begin
            state  <= STOP;
            TX_OUT <= STOP_BIT;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt <= 1'b0;
`endif
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= STOP_BIT;
`ifdef UART_TX_TWO_STOP_EN
          stop_cnt <= 1'b0;
`endif
        end
        STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          stop_cnt <= 1'b1;
`endif
          if (accept) begin
            state  <= START;
            TX_OUT <= START_BIT;
            Busy   <= 1'b1;
          end else if (last_stop) begin
            state  <= IDLE;
            TX_OUT <= IDLE_LINE;
            Busy   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= IDLE_LINE;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a frame-level model pushes expected line bits, a monitor pops them.
module tb_uart_tx_frame;

  localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int L = W + 1 + NSTOP;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] P_DATA = '0;
  logic         Data_Valid = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         TX_OUT, Busy;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  bit mon_e;

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the line is free for a new frame whenever no expected bits remain
  // beyond the one currently shown (the monitor already popped it).
  always @(posedge CLK) begin
    if (RST && Data_Valid && exp_q.size() == 0) begin
      exp_q.push_back(1'b0);
      for (int i = 0; i < W; i++) exp_q.push_back(P_DATA[i]);
      if (PAR_EN) exp_q.push_back((($countones(P_DATA) % 2) == 1) ^ PAR_TYP);
      for (int i = 0; i < NSTOP; i++) exp_q.push_back(1'b1);
    end
  end

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("busy_in_frame", Busy, 1);
      check("tx_bit", TX_OUT, mon_e);
    end else begin
      check("idle_busy", Busy, 0);
      check("idle_line", TX_OUT, 1);
    end
  end

  task automatic send(input logic [W-1:0] d, input bit pe, input bit pt,
                      output int blen, output logic [31:0] seq);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    blen = 0;
    seq  = '0;
    while (Busy && blen < 31) begin
      seq[blen] = TX_OUT;
      blen++;
      @(negedge CLK);
    end
  endtask

  task automatic drain();
    int t = 0;
    Data_Valid = 1'b0;
    while ((exp_q.size() != 0 || Busy) && t < 200) begin
      @(negedge CLK);
      t++;
    end
    check("drain_timeout", int'(t < 200), 1);
  endtask

  initial begin
    int n;
    logic [31:0] seq;

    repeat (2) @(negedge CLK);
    check("reset_tx", TX_OUT, 1);
    check("reset_busy", Busy, 0);
    #2 RST = 1'b1;
    repeat (20) @(negedge CLK);

    send(8'hA5, 1'b0, 1'b0, n, seq);
    check("len_nopar", n, L);
    check("seq_a5", int'(seq[9:0]), int'(10'b1101001010));

    send(8'h07, 1'b1, 1'b0, n, seq);
    check("len_even", n, L + 1);
    check("par_even_07", seq[9], 1);

    send(8'h07, 1'b1, 1'b1, n, seq);
    check("len_odd", n, L + 1);
    check("par_odd_07", seq[9], 0);

    // Back-to-back with Data_Valid held high.
    @(negedge CLK);
    P_DATA = 8'h55; PAR_EN = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hFF;
    n = 0;
    repeat (L) begin
      n += int'(Busy);
      @(negedge CLK);
    end
    Data_Valid = 1'b0;
    while (Busy && n < 100) begin
      n++;
      @(negedge CLK);
    end
    check("b2b_len", n, 2 * L);

    // Mid-frame input changes and a stray Data_Valid pulse in DATA.
    @(negedge CLK);
    P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    @(negedge CLK);
    P_DATA = 8'h00; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0; PAR_EN = 1'b0;
    drain();

    // Data_Valid raised only in the first stop cycle.
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (W + 1) @(negedge CLK);
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    drain();

    // Asynchronous reset in the middle of DATA.
    @(negedge CLK);
    P_DATA = 8'hA5; PAR_EN = 1'b1; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_tx", TX_OUT, 1);
    check("midrst_busy", Busy, 0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    repeat (20) @(negedge CLK);

    // Random traffic.
    repeat (800) begin
      @(negedge CLK);
      P_DATA     = W'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      Data_Valid = ($urandom_range(0, 4) < 2);
    end
    drain();
    repeat (3) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
